otter_mem_arbiter: RTL
======================

// Module: otter_mem_arbiter
// PURPOSE
//  Two-requester arbiter for the OTTER shared data-memory port.
//  Requester 0 is the CPU data path: the CU FSM memRDEN2/memWE2 strobes plus the ALU address.
//  Requester 1 is a secondary master (DMA/debug loader).
//  Serialises accesses onto one synchronous-read memory port (1-cycle read latency) using a req/ack handshake.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
// PORTS
//  clk        in   1       system clock; all state changes on posedge
//  RST        in   1       asynchronous, active-high reset
//  req0       in   1       requester 0 access request; held until ack0
//  we0        in   1       requester 0: 1=write, 0=read; stable while req0
//  addr0      in   ADDR_W  requester 0 address; stable while req0
//  wdata0     in   DATA_W  requester 0 write data; stable while req0
//  size0      in   2       requester 0 size (00 byte, 01 half, 10 word)
//  ack0       out  1       one-cycle completion pulse to requester 0
//  rdata0     out  DATA_W  read data to requester 0, valid only while ack0
//  req1,we1,addr1,wdata1,size1,ack1,rdata1   same as above, requester 1
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_size   out  2       memory access size
//  mem_rden   out  1       memory read strobe, one cycle
//  mem_we     out  1       memory write strobe, one cycle
//  mem_rdata  in   DATA_W  memory read data, valid cycle after mem_rden
//  busy       out  1       1 whenever state != ST_IDLE
//  owner      out  1       index of current/last granted requester
// BEHAVIOUR
//  Reset: async on RST=1. state=ST_IDLE, last=1, owner=0.
//   All outputs 0 the same instant RST rises, held 0 while RST=1.
//  FSM: ST_IDLE -> ST_ACCESS -> ST_RESP -> ST_IDLE. Fixed 3-cycle transaction.
//  ST_IDLE: all strobes/acks 0; busy=0. req sampled only here.
//   - no req: stay.
//   - one req: grant it (owner<=idx).
//   - both: grant !last (round-robin); go ST_ACCESS.
//  ST_ACCESS: mem_addr/wdata/size muxed from owner.
//   - mem_rden=!we_owner, mem_we=we_owner for exactly this cycle.
//   - Go ST_RESP.
//  ST_RESP: ack_owner=1 for exactly this cycle; other ack=0.
//   - rdata_owner=mem_rdata if read, 0 if write; non-owner rdata=0.
//   - last<=owner; go ST_IDLE.
//  Requester rule: drop req (or present a new one) at the edge ending ack.
//   A req still high in the following ST_IDLE is a new transaction.
//  Latency: req high in IDLE cycle N -> mem strobe N+1 -> ack N+2.
//   Max throughput is one transaction per 3 cycles.
//   Worst-case wait under contention is 6 cycles.
//  Fairness: with both req held continuously, grants alternate 0,1,0,1.
//  req dropped after grant (protocol violation): transaction still completes and ack pulses.
//  Address/size are passed unchanged; no width conversion, no alignment checks.
//  RST during ST_ACCESS: strobes drop asynchronously and the access is abandoned.
//   No ack is issued; the requester reissues.
//  RST during ST_RESP: ack suppressed.
//  Unused mem_* outputs in IDLE/RESP driven 0.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined:
//   - requester 0 always wins a tie in ST_IDLE.
//   - `last` is unused; requester 1 can starve.
//  ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
//  Handshake, latency and reset are identical in both builds.
// TESTING
//  T1 reset: RST pulse mid-cycle -> all outputs 0 asynchronously; first grant after release goes to req0.
//  T2 single read: req0=1,we0=0,addr0=0x100, mem_rdata=0xDEADBEEF
//     -> mem_rden at N+1 with mem_addr=0x100; ack0 and rdata0=0xDEADBEEF at N+2.
//  T3 single write: req1=1,we1=1,addr1=0x2000,wdata1=0x12345678,size1=10
//     -> mem_we=1 at N+1 with those values; ack1 at N+2 with rdata1=0.
//  T4 contention: req0 and req1 held through 4 transactions -> owner sequence 0,1,0,1.
//     With ARB_FIXED_PRIO_EN: 0,0,0,0.
//  T5 reset in ST_ACCESS: assert RST while mem_we=1 -> mem_we drops immediately; no ack; FSM in ST_IDLE after release.
//  T6 back-to-back: req0 reasserted with a new address the cycle after ack0
//     -> second strobe exactly 3 cycles after the first.

Source files
------------

// File: rtl/otter_mem_arbiter_if.sv
// Shared data-memory port bundle for otter_mem_arbiter.
// Carries both requester handshakes and the synchronous-read memory port.
interface otter_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic [1:0]        size0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        size1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_rden;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  req0, we0, addr0, wdata0, size0,
        input  req1, we1, addr1, wdata1, size1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_wdata, mem_size, mem_rden, mem_we,
        output busy, owner
    );

    modport master (
        output req0, we0, addr0, wdata0, size0,
        output req1, we1, addr1, wdata1, size1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_wdata, mem_size, mem_rden, mem_we,
        input  busy, owner
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Two-requester arbiter serialising accesses onto one 1-cycle-latency memory port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module otter_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 RST,
    otter_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_q;
    logic              owner_nxt;
    logic              tie_pick;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [1:0]        size_sel;
    logic [DATA_W-1:0] rd_sel;

`ifdef ARB_FIXED_PRIO_EN
    always_comb tie_pick = 1'b0;
`else
    logic last_q;

    // last starts at 1 so the first tie after reset goes to requester 0
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            last_q <= 1'b1;
        else if (state == ST_RESP)
            last_q <= owner_q;
    end

    always_comb tie_pick = ~last_q;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            owner_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        case (state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nxt = ST_ACCESS;
                    if (bus.req0 && bus.req1)
                        owner_nxt = tie_pick;
                    else
                        owner_nxt = bus.req1;
                end
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        we_sel    = owner_q ? bus.we1    : bus.we0;
        addr_sel  = owner_q ? bus.addr1  : bus.addr0;
        wdata_sel = owner_q ? bus.wdata1 : bus.wdata0;
        size_sel  = owner_q ? bus.size1  : bus.size0;
        rd_sel    = we_sel ? '0 : bus.mem_rdata;
    end

    // Outputs decode purely from registered state, so reset clears them asynchronously
    always_comb begin
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;
        bus.rdata0    = '0;
        bus.rdata1    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        bus.mem_rden  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.busy      = (state != ST_IDLE);
        bus.owner     = owner_q;
        case (state)
            ST_ACCESS: begin
                bus.mem_addr  = addr_sel;
                bus.mem_wdata = wdata_sel;
                bus.mem_size  = size_sel;
                bus.mem_rden  = ~we_sel;
                bus.mem_we    = we_sel;
            end
            ST_RESP: begin
                if (owner_q) begin
                    bus.ack1   = 1'b1;
                    bus.rdata1 = rd_sel;
                end else begin
                    bus.ack0   = 1'b1;
                    bus.rdata0 = rd_sel;
                end
            end
            default: ;
        endcase
    end
endmodule
